neurona_serial: RTL and testbench

Streaming single neuron for the 7x7 binary-pixel classifier. It consumes one (pixel, signed weight) pair per accepted beat and accumulates the weighted sum plus a bias over N_INPUTS beats. It then applies an optional ReLU and saturates the result to OUT_WIDTH. The result is presented on a valid/ready output port. It is the consuming end of the pixel/weight stimulus that the neuron testers drive, serialised so that one MAC datapath serves all 49 inputs.

---
 rtl/neurona_pkg.sv | 18 +
 rtl/neurona_activacion.sv | 30 +++
 rtl/neurona_serial.sv | 102 ++++++++++
 tb/tb_neurona_serial.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/neurona_pkg.sv
// rtl/neurona_pkg.sv - shared types and constants for the serial neuron
package neurona_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        DONE
    } state_t;

    localparam int N_PIXELS = 49;
    localparam int W_WIDTH  = 8;

    // The beat counter must be able to hold N_INPUTS itself after the last beat.
    function automatic int count_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/neurona_activacion.sv
// rtl/neurona_activacion.sv - optional ReLU followed by signed saturation to OUT_WIDTH
module neurona_activacion #(
    parameter int ACC_WIDTH = 14,
    parameter int OUT_WIDTH = 8,
    parameter int RELU      = 1
) (
    input  logic signed [ACC_WIDTH-1:0] acc_i,
    output logic signed [OUT_WIDTH-1:0] value_o,
    output logic                        sat_o
);

    localparam logic signed [ACC_WIDTH-1:0] MAX_V = ACC_WIDTH'((1 << (OUT_WIDTH - 1)) - 1);
    localparam logic signed [ACC_WIDTH-1:0] MIN_V = ~MAX_V;

    logic signed [ACC_WIDTH-1:0] relu_v;

    always_comb begin
        relu_v  = ((RELU != 0) && acc_i[ACC_WIDTH-1]) ? '0 : acc_i;
        sat_o   = 1'b0;
        value_o = relu_v[OUT_WIDTH-1:0];
        if (relu_v > MAX_V) begin
            value_o = MAX_V[OUT_WIDTH-1:0];
            sat_o   = 1'b1;
        end else if (relu_v < MIN_V) begin
            value_o = MIN_V[OUT_WIDTH-1:0];
            sat_o   = 1'b1;
        end
    end

endmodule

// File: rtl/neurona_serial.sv
// rtl/neurona_serial.sv - streaming single neuron: serial MAC over N_INPUTS pixel/weight beats
module neurona_serial #(
    parameter int N_INPUTS  = neurona_pkg::N_PIXELS,
    parameter int W_WIDTH   = neurona_pkg::W_WIDTH,
    parameter int ACC_WIDTH = 14,
    parameter int OUT_WIDTH = 8,
    parameter int RELU      = 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic signed [W_WIDTH-1:0]   bias,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic                        in_pixel,
    input  logic signed [W_WIDTH-1:0]   in_weight,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic signed [OUT_WIDTH-1:0] out_value,
    output logic                        out_sat
);

    import neurona_pkg::*;

    localparam int COUNT_WIDTH = count_width(N_INPUTS);

    state_t                      state_q;
    logic [COUNT_WIDTH-1:0]      count_q, count_d;
    logic signed [ACC_WIDTH-1:0] acc_q, acc_d, term_d, base_d;
    logic                        in_ready_q, out_valid_q, out_sat_q;
    logic signed [OUT_WIDTH-1:0] out_value_q;
    logic signed [OUT_WIDTH-1:0] act_value;
    logic                        act_sat;
    logic                        beat, last_beat;

    assign beat = in_valid && in_ready_q;

    // The first beat of an inference folds the bias in, so no separate bias cycle is needed.
    always_comb begin
        term_d    = in_pixel ? {{(ACC_WIDTH - W_WIDTH){in_weight[W_WIDTH-1]}}, in_weight} : '0;
        base_d    = (state_q == IDLE) ? {{(ACC_WIDTH - W_WIDTH){bias[W_WIDTH-1]}}, bias} : acc_q;
        acc_d     = base_d + term_d;
        count_d   = (state_q == IDLE) ? COUNT_WIDTH'(1) : count_q + 1'b1;
        last_beat = (state_q == IDLE) ? (N_INPUTS == 1) : (count_q == COUNT_WIDTH'(N_INPUTS - 1));
    end

    neurona_activacion #(
        .ACC_WIDTH(ACC_WIDTH),
        .OUT_WIDTH(OUT_WIDTH),
        .RELU     (RELU)
    ) u_activacion (
        .acc_i  (acc_d),
        .value_o(act_value),
        .sat_o  (act_sat)
    );

    // The activation sees the sum including the last term, giving a one-cycle result latency.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            count_q     <= '0;
            acc_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_value_q <= '0;
            out_sat_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE, ACCUM: begin
                    if (beat) begin
                        acc_q   <= acc_d;
                        count_q <= count_d;
                        if (last_beat) begin
                            state_q     <= DONE;
                            in_ready_q  <= 1'b0;
                            out_valid_q <= 1'b1;
                            out_value_q <= act_value;
                            out_sat_q   <= act_sat;
                        end else begin
                            state_q <= ACCUM;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q     <= IDLE;
                        count_q     <= '0;
                        acc_q       <= '0;
                        in_ready_q  <= 1'b1;
                        out_valid_q <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_value = out_value_q;
    assign out_sat   = out_sat_q;

endmodule

// File: tb/tb_neurona_serial.sv
// tb/tb_neurona_serial.sv - directed bench for neurona_serial, RELU=1 and RELU=0 instances side by side
module tb_neurona_serial;

    logic              clk = 1'b0;
    logic              reset;
    logic signed [7:0] bias;
    logic              in_valid;
    logic              in_pixel;
    logic signed [7:0] in_weight;
    logic              out_ready;

    logic              in_ready1, out_valid1, out_sat1;
    logic signed [7:0] out_value1;
    logic              in_ready0, out_valid0, out_sat0;
    logic signed [7:0] out_value0;

    always #5 clk = ~clk;

    neurona_serial #(.N_INPUTS(49), .W_WIDTH(8), .ACC_WIDTH(14), .OUT_WIDTH(8), .RELU(1)) dut_r1 (
        .clk(clk), .reset(reset), .bias(bias), .in_valid(in_valid), .in_ready(in_ready1),
        .in_pixel(in_pixel), .in_weight(in_weight), .out_valid(out_valid1),
        .out_ready(out_ready), .out_value(out_value1), .out_sat(out_sat1)
    );

    neurona_serial #(.N_INPUTS(49), .W_WIDTH(8), .ACC_WIDTH(14), .OUT_WIDTH(8), .RELU(0)) dut_r0 (
        .clk(clk), .reset(reset), .bias(bias), .in_valid(in_valid), .in_ready(in_ready0),
        .in_pixel(in_pixel), .in_weight(in_weight), .out_valid(out_valid0),
        .out_ready(out_ready), .out_value(out_value0), .out_sat(out_sat0)
    );

    int checks = 0;
    int errors = 0;
    bit chk_en = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int activate(input int s, input bit relu, output bit sat);
        int v;
        v   = (relu && s < 0) ? 0 : s;
        sat = 1'b0;
        if (v > 127) begin
            v = 127; sat = 1'b1;
        end else if (v < -128) begin
            v = -128; sat = 1'b1;
        end
        return v;
    endfunction

    // Transaction-level model: integer running sum over accepted beats, result pending until taken.
    int m_sum, m_count;
    bit m_ov;
    int m_val1, m_val0;
    bit m_sat1, m_sat0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_sum = 0; m_count = 0; m_ov = 0;
        end else if (m_ov) begin
            if (out_ready) begin
                m_ov = 0; m_sum = 0; m_count = 0;
            end
        end else if (in_valid) begin
            if (m_count == 0) m_sum = int'(bias);
            if (in_pixel) m_sum += int'(in_weight);
            m_count++;
            if (m_count == 49) begin
                m_ov   = 1;
                m_val1 = activate(m_sum, 1'b1, m_sat1);
                m_val0 = activate(m_sum, 1'b0, m_sat0);
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en && !reset) begin
            check("in_ready_r1", int'(in_ready1), int'(!m_ov));
            check("in_ready_r0", int'(in_ready0), int'(!m_ov));
            check("out_valid_r1", int'(out_valid1), int'(m_ov));
            check("out_valid_r0", int'(out_valid0), int'(m_ov));
            if (m_ov) begin
                check("model_value_r1", int'(out_value1), m_val1);
                check("model_sat_r1", int'(out_sat1), int'(m_sat1));
                check("model_value_r0", int'(out_value0), m_val0);
                check("model_sat_r0", int'(out_sat0), int'(m_sat0));
            end
        end
    end

    int w_vec[49];
    bit p_vec[49];
    int w_first[49] = '{-1, -2, -3, -2, 0, 1, 0, 0, 0, 2, 0, 1, 1, 4, 0, 0, 3, -1, 1, 0,
                        1, 1, 1, 2, 3, 6, 1, 0, -2, -2, 1, 2, -1, -1, -2, -2, -4, -4, 1, 0,
                        -1, -2, -1, 0, 2, 2, 2, 1, -1};

    task automatic load_vec(input bit first, input int w, input bit p);
        for (int i = 0; i < 49; i++) begin
            w_vec[i] = first ? w_first[i] : w;
            p_vec[i] = first ? 1'b1 : p;
        end
    endtask

    task automatic run_vec(input string name, input int b, input bit gaps, input int hold,
                           input int stop_after, input int e1, input int s1, input int e0, input int s0);
        int  n;
        int  cyc;
        bit  v;
        bit  rdy;
        logic signed [7:0] held1;
        logic              held_sat1;
        n = 0;
        cyc = 0;
        bias = 8'(b);
        out_ready = (hold == 0);
        while (n < stop_after && cyc < 2000) begin
            v = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            in_valid  = v;
            in_pixel  = v ? p_vec[n] : 1'($urandom_range(0, 1));
            in_weight = v ? 8'(w_vec[n]) : 8'($urandom);
            if (n > 0) bias = 8'($urandom);
            rdy = in_ready1;
            @(posedge clk); #1;
            cyc++;
            if (v && rdy) n++;
        end
        in_valid = 1'b0;
        if (cyc >= 2000) check({name, "_beat_timeout"}, n, stop_after);
        if (stop_after < 49) return;
        check({name, "_latency_valid"}, int'(out_valid1), 1);
        check({name, "_model_pin_value1"}, m_val1, e1);
        check({name, "_value_r1"}, int'(out_value1), e1);
        check({name, "_sat_r1"}, int'(out_sat1), s1);
        check({name, "_value_r0"}, int'(out_value0), e0);
        check({name, "_sat_r0"}, int'(out_sat0), s0);
        check({name, "_in_ready_low"}, int'(in_ready1), 0);
        held1 = out_value1;
        held_sat1 = out_sat1;
        for (int i = 0; i < hold; i++) begin
            in_valid  = 1'b1;
            in_pixel  = 1'b1;
            in_weight = 8'($urandom);
            @(posedge clk); #1;
            check({name, "_hold_valid"}, int'(out_valid1), 1);
            check({name, "_hold_value"}, int'(out_value1), int'(held1));
            check({name, "_hold_sat"}, int'(out_sat1), int'(held_sat1));
            check({name, "_hold_in_ready"}, int'(in_ready1), 0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check({name, "_in_ready_back"}, int'(in_ready1), 1);
        check({name, "_valid_cleared"}, int'(out_valid1), 0);
    endtask

    initial begin
        reset = 1'b1;
        bias = '0;
        in_valid = 1'b0;
        in_pixel = 1'b0;
        in_weight = '0;
        out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("reset_out_valid", int'(out_valid1), 0);
        check("reset_out_value", int'(out_value1), 0);
        check("reset_out_sat", int'(out_sat1), 0);
        #1 reset = 1'b0;
        @(posedge clk); #1;
        check("reset_in_ready", int'(in_ready1), 1);
        chk_en = 1;

        load_vec(1'b1, 0, 1'b0);
        run_vec("first_vec", 0, 1'b0, 0, 49, 7, 0, 7, 0);

        load_vec(1'b0, 127, 1'b0);
        run_vec("pixels_zero", -5, 1'b0, 0, 49, 0, 0, -5, 0);

        load_vec(1'b0, 127, 1'b1);
        run_vec("sat_high", 127, 1'b0, 0, 49, 127, 1, 127, 1);

        load_vec(1'b0, -128, 1'b1);
        run_vec("sat_low", -128, 1'b0, 0, 49, 0, 0, -128, 1);

        load_vec(1'b1, 0, 1'b0);
        run_vec("gaps", 0, 1'b1, 0, 49, 7, 0, 7, 0);

        run_vec("backpressure", 0, 1'b0, 5, 49, 7, 0, 7, 0);

        run_vec("partial", 0, 1'b0, 0, 20, 0, 0, 0, 0);
        #2 reset = 1'b1;
        @(negedge clk);
        check("midreset_out_valid", int'(out_valid1), 0);
        check("midreset_out_value", int'(out_value1), 0);
        check("midreset_in_ready", int'(in_ready1), 1);
        #1 reset = 1'b0;
        #1;
        check("after_reset_in_ready", int'(in_ready1), 1);
        check("after_reset_out_valid", int'(out_valid1), 0);
        @(posedge clk); #1;
        run_vec("after_reset", 0, 1'b0, 0, 49, 7, 0, 7, 0);

        chk_en = 0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
